// File: rtl/crack_pkg.sv
// Shared constants and state encodings for the crack dispatcher and its worker slots.
package crack_pkg;

    localparam int CHARSET_SIZE = 36;
    localparam int CHAR_MAX     = CHARSET_SIZE - 1;
    localparam int ASCII_BASE   = 48;

    typedef enum logic [1:0] {
        FREE,
        LOAD,
        ACTIVE
    } slot_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ABORT,
        FINISH
    } top_state_t;

endpackage

// File: rtl/crack_slot.sv
// One worker slot: holds the job bounds and sequences the worker's rst/run handshake.
//   state  | meaning
//   FREE   | worker held in reset, slot can take a job
//   LOAD   | bounds registered, worker still in reset so it loads them
//   ACTIVE | worker running, waiting for its done
module crack_slot
    import crack_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic       abort,
    input  logic [5:0] job_from,
    input  logic [5:0] job_to,
    input  logic       w_found,
    input  logic       w_done,
    output logic       w_rst,
    output logic [5:0] w_from,
    output logic [5:0] w_to,
    output logic       is_free,
    output logic       hit
);

    slot_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FREE;
            w_rst  <= 1'b1;
            w_from <= '0;
            w_to   <= '0;
        end else if (abort) begin
            // bounds are kept so the hit's job stays visible after the abort
            state <= FREE;
            w_rst <= 1'b1;
        end else begin
            case (state)
                FREE: begin
                    if (issue) begin
                        state  <= LOAD;
                        w_from <= job_from;
                        w_to   <= job_to;
                    end
                end
                LOAD: begin
                    state <= ACTIVE;
                    w_rst <= 1'b0;
                end
                ACTIVE: begin
                    if (w_done) begin
                        state <= FREE;
                        w_rst <= 1'b1;
                    end
                end
                default: begin
                    state <= FREE;
                    w_rst <= 1'b1;
                end
            endcase
        end
    end

    assign is_free = (state == FREE);
    assign hit     = (state == ACTIVE) && w_found;

endmodule

// File: rtl/crack_dispatcher.sv
// Splits the first-character range into chunks and farms them out to password_cracker workers.
// Optional search time limit under CRACK_DISPATCH_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | issuing chunks, watching worker results
//   ABORT  | one cycle with every worker held in reset after a hit or timeout
//   FINISH | result published, done high
module crack_dispatcher
    import crack_pkg::*;
#(
    parameter int NUM_WORKERS = 4,
    parameter int CHUNK       = 9
`ifdef CRACK_DISPATCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    input  logic [31:0]                                            password,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   found,
    output logic [((NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1)-1:0] found_slot,
    output logic [5:0]                                             found_from,
    output logic [NUM_WORKERS-1:0]                                 w_rst,
    output logic [NUM_WORKERS*6-1:0]                               w_from,
    output logic [NUM_WORKERS*6-1:0]                               w_to,
    output logic [31:0]                                            w_password,
    input  logic [NUM_WORKERS-1:0]                                 w_found,
    input  logic [NUM_WORKERS-1:0]                                 w_done
`ifdef CRACK_DISPATCH_TIMEOUT_EN
    , output logic                                                 timeout
`endif
);

    localparam int SW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    top_state_t             state;
    logic [6:0]             next_from;
    logic [6:0]             to_raw;
    logic [5:0]             issue_to;
    logic [NUM_WORKERS-1:0] slot_free;
    logic [NUM_WORKERS-1:0] slot_hit;
    logic [NUM_WORKERS-1:0] issue_vec;
    logic [SW-1:0]          free_sel;
    logic [SW-1:0]          hit_sel;
    logic [5:0]             hit_from;
    logic                   free_any;
    logic                   hit_any;
    logic                   tmo_hit;
    logic                   accept;
    logic                   abort_slots;
    logic                   can_issue;
    logic                   exhausted;

    // Descending scan so the lowest index wins both selections.
    always_comb begin
        free_sel = '0;
        free_any = 1'b0;
        hit_sel  = '0;
        hit_any  = 1'b0;
        hit_from = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (slot_free[i]) begin
                free_sel = SW'(i);
                free_any = 1'b1;
            end
            if (slot_hit[i]) begin
                hit_sel  = SW'(i);
                hit_any  = 1'b1;
                hit_from = w_from[i*6 +: 6];
            end
        end
    end

    assign accept      = start && ((state == IDLE) || (state == FINISH));
    assign to_raw      = next_from + 7'(CHUNK - 1);
    assign issue_to    = (to_raw > 7'(CHAR_MAX)) ? 6'(CHAR_MAX) : to_raw[5:0];
    assign can_issue   = (state == RUN) && !hit_any && !tmo_hit && free_any
                         && (next_from <= 7'(CHAR_MAX));
    assign issue_vec   = can_issue ? (NUM_WORKERS'(1) << free_sel) : '0;
    assign exhausted   = (next_from > 7'(CHAR_MAX)) && (&slot_free);
    assign abort_slots = ((state == RUN) && (hit_any || tmo_hit)) || (state == ABORT);

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_slot
        crack_slot u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .issue    (issue_vec[g]),
            .abort    (abort_slots),
            .job_from (next_from[5:0]),
            .job_to   (issue_to),
            .w_found  (w_found[g]),
            .w_done   (w_done[g]),
            .w_rst    (w_rst[g]),
            .w_from   (w_from[g*6 +: 6]),
            .w_to     (w_to[g*6 +: 6]),
            .is_free  (slot_free[g]),
            .hit      (slot_hit[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            found_slot <= '0;
            found_from <= '0;
            w_password <= '0;
            next_from  <= '0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (accept) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        found      <= 1'b0;
                        w_password <= password;
                        next_from  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (hit_any) begin
                        found      <= 1'b1;
                        found_slot <= hit_sel;
                        found_from <= hit_from;
                        state      <= ABORT;
                    end else if (tmo_hit) begin
                        state <= ABORT;
                    end else if (exhausted) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else if (can_issue) begin
                        next_from <= next_from + 7'(CHUNK);
                    end
                end
                ABORT: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRACK_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == RUN) && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
            timeout <= 1'b0;
        end else begin
            if (busy && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - TW'(1);
            if (tmo_hit && !hit_any) timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_crack_dispatcher.sv
// Directed bench for crack_dispatcher with behavioural workers (fixed latency, match on first char).
module tb_crack_dispatcher;
    import crack_pkg::*;

    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // four-slot instance
    logic        start4 = 1'b0;
    logic [31:0] pw4    = '0;
    logic        busy4, done4, found4;
    logic [1:0]  fslot4;
    logic [5:0]  ffrom4;
    logic [3:0]  wrst4, wfound4, wdone4;
    logic [23:0] wfrom4, wto4;
    logic [31:0] wpw4;
`ifdef CRACK_DISPATCH_TIMEOUT_EN
    logic        tmo4;
`endif

    crack_dispatcher #(.NUM_WORKERS(4), .CHUNK(9)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .password(pw4),
        .busy(busy4), .done(done4), .found(found4), .found_slot(fslot4),
        .found_from(ffrom4), .w_rst(wrst4), .w_from(wfrom4), .w_to(wto4),
        .w_password(wpw4), .w_found(wfound4), .w_done(wdone4)
`ifdef CRACK_DISPATCH_TIMEOUT_EN
        , .timeout(tmo4)
`endif
    );

    // two-slot instance
    logic        start2 = 1'b0;
    logic [31:0] pw2    = '0;
    logic        busy2, done2, found2;
    logic [0:0]  fslot2;
    logic [5:0]  ffrom2;
    logic [1:0]  wrst2, wfound2, wdone2;
    logic [11:0] wfrom2, wto2;
    logic [31:0] wpw2;
`ifdef CRACK_DISPATCH_TIMEOUT_EN
    logic        tmo2;
`endif

    crack_dispatcher #(.NUM_WORKERS(2), .CHUNK(9)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .password(pw2),
        .busy(busy2), .done(done2), .found(found2), .found_slot(fslot2),
        .found_from(ffrom2), .w_rst(wrst2), .w_from(wfrom2), .w_to(wto2),
        .w_password(wpw2), .w_found(wfound2), .w_done(wdone2)
`ifdef CRACK_DISPATCH_TIMEOUT_EN
        , .timeout(tmo2)
`endif
    );

`ifdef CRACK_DISPATCH_TIMEOUT_EN
    // workers that never answer, so only the time limit can end the search
    logic        start_t = 1'b0;
    logic [31:0] pw_t    = '0;
    logic        busy_t, done_t, found_t, tmo_t;
    logic [1:0]  fslot_t;
    logic [5:0]  ffrom_t;
    logic [3:0]  wrst_t;
    logic [3:0]  wquiet_t = '0;
    logic [23:0] wfrom_t, wto_t;
    logic [31:0] wpw_t;

    crack_dispatcher #(.NUM_WORKERS(4), .CHUNK(9), .TIMEOUT_CYCLES(50)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .password(pw_t),
        .busy(busy_t), .done(done_t), .found(found_t), .found_slot(fslot_t),
        .found_from(ffrom_t), .w_rst(wrst_t), .w_from(wfrom_t), .w_to(wto_t),
        .w_password(wpw_t), .w_found(wquiet_t), .w_done(wquiet_t), .timeout(tmo_t)
    );
`endif

    function automatic logic hit_chk(logic [31:0] pw, logic [5:0] f, logic [5:0] t);
        logic [7:0] d;
        d = pw[31:24] - 8'(ASCII_BASE);
        return (d >= {2'b00, f}) && (d <= {2'b00, t});
    endfunction

    int cnt4 [4];
    int cnt2 [2];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wrst4[i]) cnt4[i] <= 0; else if (cnt4[i] < LAT) cnt4[i] <= cnt4[i] + 1;
        for (int i = 0; i < 2; i++)
            if (wrst2[i]) cnt2[i] <= 0; else if (cnt2[i] < LAT) cnt2[i] <= cnt2[i] + 1;
    end

    always_comb begin
        wdone4  = '0;
        wfound4 = '0;
        wdone2  = '0;
        wfound2 = '0;
        for (int i = 0; i < 4; i++) begin
            wdone4[i]  = !wrst4[i] && (cnt4[i] == LAT);
            wfound4[i] = wdone4[i] && hit_chk(wpw4, wfrom4[i*6 +: 6], wto4[i*6 +: 6]);
        end
        for (int i = 0; i < 2; i++) begin
            wdone2[i]  = !wrst2[i] && (cnt2[i] == LAT);
            wfound2[i] = wdone2[i] && hit_chk(wpw2, wfrom2[i*6 +: 6], wto2[i*6 +: 6]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input int d, input logic [31:0] pw);
        @(negedge clk);
        if (d == 0) begin pw4 = pw; start4 = 1'b1; end
        else        begin pw2 = pw; start2 = 1'b1; end
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
    endtask

    // the two-slot w_rst is padded with ones so "all in reset" reads 4'hF for either instance
    task automatic sample(input int d, output logic dn, output logic bs, output logic fd,
                          output logic [3:0] wr, output int sl, output int fr,
                          output logic [31:0] wp);
        if (d == 0) begin
            dn = done4; bs = busy4; fd = found4; wr = wrst4;
            sl = int'(fslot4); fr = int'(ffrom4); wp = wpw4;
        end else begin
            dn = done2; bs = busy2; fd = found2; wr = {2'b11, wrst2};
            sl = int'(fslot2); fr = int'(ffrom2); wp = wpw2;
        end
    endtask

    typedef struct {
        int          dut;
        logic [31:0] pw;
        logic        exp_found;
        int          exp_slot;
        int          exp_from;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        logic        dn, bs, fd, saw_abort;
        logic [3:0]  wr, wr_abort;
        logic [31:0] wp;
        int          sl, fr, n;
        do_start(v.dut, v.pw);
        sample(v.dut, dn, bs, fd, wr, sl, fr, wp);
        chk($sformatf("v%0d busy_after_start", idx), 32'(bs), 32'd1);
        chk($sformatf("v%0d done_cleared", idx), 32'(dn), 32'd0);
        chk($sformatf("v%0d w_password", idx), wp, v.pw);
        saw_abort = 1'b0;
        wr_abort  = '0;
        n = 0;
        while (!dn && n < 300) begin
            @(negedge clk);
            n++;
            sample(v.dut, dn, bs, fd, wr, sl, fr, wp);
            if (fd && !dn && !saw_abort) begin
                saw_abort = 1'b1;
                wr_abort  = wr;
            end
        end
        chk($sformatf("v%0d done", idx), 32'(dn), 32'd1);
        chk($sformatf("v%0d busy_end", idx), 32'(bs), 32'd0);
        chk($sformatf("v%0d found", idx), 32'(fd), 32'(v.exp_found));
        if (v.exp_found) begin
            chk($sformatf("v%0d found_slot", idx), 32'(sl), 32'(v.exp_slot));
            chk($sformatf("v%0d found_from", idx), 32'(fr), 32'(v.exp_from));
            chk($sformatf("v%0d abort_w_rst", idx), {27'd0, saw_abort, wr_abort}, {27'd0, 1'b1, 4'hF});
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{0, "0000", 1'b1, 0, 0};
        vecs[1] = '{0, "9000", 1'b1, 1, 9};
        vecs[2] = '{0, "I000", 1'b1, 2, 18};
        vecs[3] = '{0, "S000", 1'b1, 3, 27};
        vecs[4] = '{0, "////", 1'b0, 0, 0};
        vecs[5] = '{0, "R000", 1'b1, 3, 27};
        vecs[6] = '{1, "0000", 1'b1, 0, 0};
        vecs[7] = '{1, "I000", 1'b1, 0, 18};
        vecs[8] = '{1, "R000", 1'b1, 1, 27};
        vecs[9] = '{1, "////", 1'b0, 0, 0};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst done", 32'(done4), 32'd0);
        chk("rst found", 32'(found4), 32'd0);
        chk("rst found_slot", 32'(fslot4), 32'd0);
        chk("rst found_from", 32'(ffrom4), 32'd0);
        chk("rst w_rst", 32'(wrst4), 32'hF);
        chk("rst w_from", 32'(wfrom4), 32'd0);
        chk("rst w_to", 32'(wto4), 32'd0);
        chk("rst w_password", wpw4, 32'd0);
        rst_n = 1'b1;

        // cycle-accurate dispatch and hit sequence
        do_start(0, "0000");
        chk("seq busy E", 32'(busy4), 32'd1);
        chk("seq w_rst E", 32'(wrst4), 32'hF);
        @(negedge clk);
        chk("seq w_rst E+1", 32'(wrst4), 32'hF);
        chk("seq from0 E+1", 32'(wfrom4[5:0]), 32'd0);
        chk("seq to0 E+1", 32'(wto4[5:0]), 32'd8);
        @(negedge clk);
        chk("seq w_rst E+2", 32'(wrst4), 32'hE);
        repeat (2) @(negedge clk);
        chk("seq w_rst E+4", 32'(wrst4), 32'h8);
        chk("seq w_from E+4", 32'(wfrom4), {8'd0, 6'd27, 6'd18, 6'd9, 6'd0});
        chk("seq w_to E+4", 32'(wto4), {8'd0, 6'd35, 6'd26, 6'd17, 6'd8});
        @(negedge clk);
        chk("seq found E+5", 32'(found4), 32'd0);
        @(negedge clk);
        chk("seq abort w_rst", 32'(wrst4), 32'hF);
        chk("seq abort found", 32'(found4), 32'd1);
        chk("seq abort done", 32'(done4), 32'd0);
        chk("seq abort busy", 32'(busy4), 32'd1);
        @(negedge clk);
        chk("seq finish done", 32'(done4), 32'd1);
        chk("seq finish busy", 32'(busy4), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        chk("two-slot last w_to", 32'(wto2[11:6]), 32'd35);

        // start while busy is ignored, then reset mid-search
        do_start(0, "////");
        repeat (2) @(negedge clk);
        do_start(0, "0000");
        chk("busy start ignored pw", wpw4, "////");
        chk("busy start still busy", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy4), 32'd0);
        chk("midrst w_rst", 32'(wrst4), 32'hF);
        chk("midrst w_password", wpw4, 32'd0);
        chk("midrst w_from", 32'(wfrom4), 32'd0);
        chk("midrst found", 32'(found4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef CRACK_DISPATCH_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            pw_t = "////";
            start_t = 1'b1;
            @(negedge clk);
            start_t = 1'b0;
            n = 0;
            while (!done_t && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("tmo done", 32'(done_t), 32'd1);
            chk("tmo timeout", 32'(tmo_t), 32'd1);
            chk("tmo found", 32'(found_t), 32'd0);
            chk("tmo w_rst", 32'(wrst_t), 32'hF);
            @(negedge clk);
            start_t = 1'b1;
            @(negedge clk);
            start_t = 1'b0;
            chk("tmo cleared", 32'(tmo_t), 32'd0);
            chk("tmo restart busy", 32'(busy_t), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crack_dispatcher.md
# crack_dispatcher

Job dispatcher that drives an array of `password_cracker` workers. It splits the first-character search range 0..35 into fixed-size chunks and issues each chunk as a from/to job to an idle worker. It collects each worker's found/done, aborts all workers on the first hit, and reports the result to the host. It is the initiator side of the worker job protocol: worker `rst` high loads from/to, `rst` low runs, `found`/`done` report back.

## Interface
- `NUM_WORKERS`, default 4: number of worker slots (1..8).
- `CHUNK`, default 9: first-character values per job (1..36).
- `clk`  in  1: sole clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: one-cycle job request; ignored unless `busy`=0.
- `password`  in  32: four ASCII characters, MSB char first; sampled on `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until completion.
- `done`  out  1: high after completion; held until next accepted `start`.
- `found`  out  1: valid with `done`; 1 = a worker matched.
- `found_slot`  out  $clog2(NUM_WORKERS) (min 1): index of the matching worker.
- `found_from`  out  6: `from` of the matching job.
- `w_rst`  out  NUM_WORKERS: per-worker reset/load, active-high (worker protocol).
- `w_from`, `w_to`  out  NUM_WORKERS×6: per-worker job bounds, flattened, slot 0 in the LSBs.
- `w_password`  out  32: registered copy of `password`, broadcast to all workers.
- `w_found`, `w_done`  in  NUM_WORKERS: worker results.

## Operation
- Reset values: `busy`=0, `done`=0, `found`=0, `found_slot`=0, `found_from`=0, `w_rst`=all 1, `w_from`/`w_to`=0, `w_password`=0, `next_from`=0.
- Top FSM has four states.
  - IDLE: on `start`, latch `w_password`, set `next_from`=0, clear `done`/`found`, go to RUN.
  - RUN: dispatch chunks and watch for results, as described below.
  - ABORT: assert `w_rst`=all 1 for one cycle, then go to FINISH.
  - FINISH: set `done`=1, clear `busy`, go to IDLE.
- Per-slot FSM has three states.
  - FREE: `w_rst`=1.
  - LOAD: `w_rst`=1, `w_from`/`w_to` already stable.
  - ACTIVE: `w_rst`=0.
  - FREE→LOAD on issue. LOAD→ACTIVE on the next cycle. ACTIVE→FREE when `w_done` is sampled.
- Issue rules in RUN:
  - At most one issue per cycle, to the lowest-index FREE slot.
  - Only when `next_from` ≤ 35.
  - The issued job gets `w_to` = min(`next_from`+CHUNK−1, 35).
  - `next_from` then advances by CHUNK. Arithmetic is 7-bit internally, so no 6-bit wrap.
- `w_found`/`w_done` are sampled only for ACTIVE slots; FREE/LOAD slots are ignored.
- Any ACTIVE slot with `w_found`=1 ends the search:
  - Record the lowest such index as `found_slot` and its `w_from` as `found_from`.
  - Set `found`=1 and go to ABORT.
  - `found` takes priority over a simultaneous `w_done` on any slot.
- Exhaustion: `next_from` > 35 and all slots FREE means the search failed. Go to FINISH with `found`=0.
- `start` while `busy`=1 is ignored with no side effects.
- `rst_n` low mid-search forces every register to its reset value immediately. `w_rst` going to all 1 halts the workers.

## Timing
- Accepted `start` at edge E: `busy`=1 after E.
- First issue is in the cycle after E. The first slot reaches LOAD after E+1 and ACTIVE (`w_rst` falls) after E+2.
- Job k (0-based) is issued no earlier than cycle E+1+k.
- Hit: worker `found` sampled at edge F gives ABORT after F, with `w_rst`=all 1 and `found`=1. `done`=1 and `busy`=0 follow after F+1 (FINISH), and the FSM is back in IDLE after F+2.
- Exhaustion: FINISH is entered the cycle after the last slot returns to FREE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CRACK_DISPATCH_TIMEOUT_EN` defined:
  - Adds parameter `TIMEOUT_CYCLES` (default 2000000) and output `timeout` (1 bit, reset 0).
  - A cycle counter runs while `busy`=1. On reaching the limit it forces ABORT, then FINISH, with `found`=0 and `timeout`=1.
  - `timeout` clears on the next accepted `start`.
  - A hit in the same cycle as the timeout wins: `found`=1, `timeout`=0.
- Undefined: no counter, no `timeout` port, and no limit on search time.

## Structure
- Shared package `crack_pkg` holds:
  - `CHARSET_SIZE`=36, `CHAR_MAX`=35, `ASCII_BASE`=48;
  - slot state enum `slot_state_t` {FREE, LOAD, ACTIVE};
  - top state enum {IDLE, RUN, ABORT, FINISH}.
- One sub-module, `crack_slot`, instantiated NUM_WORKERS times. Each instance holds its slot FSM, its `w_from`/`w_to` registers and `w_rst`, and returns FREE/found/done flags.
- Lowest-free-slot and lowest-found-slot selection stay in the top module.

## Test plan
- "0000", 4 workers, CHUNK 9 → `found`=1, `found_slot`=0, `found_from`=0. Jobs issued: 0–8, 9–17, 18–26, 27–35.
- "S000" (first digit 35) → `found`=1, `found_slot`=3, `found_from`=27. All `w_rst`=1 in the ABORT cycle.
- "////" (digits 63, never match) → all four jobs return `done`; `done`=1, `found`=0, `busy`=0.
- NUM_WORKERS 2, CHUNK 9, "R000" (digit 34) → slot 0 is reused or slot 1 takes 27–35. `found_from`=27, and `w_to` of the last job is 35.
- `start` pulse while `busy` with a different password → `w_password` unchanged. Then `rst_n` low mid-search → all outputs return to reset values within the same cycle.
- `CRACK_DISPATCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50, "////" → `done`=1, `timeout`=1, `found`=0.
